// File: rtl/alu_issue_seq.sv
// Issue/writeback sequencer around an external 16-bit ALU: fetches operands
// from an 8-entry register file, drives the ALU, and writes results back.
module alu_issue_seq #(
   parameter int DATA_W  = 16,
   parameter int REG_CNT = 8,
   parameter int ADDR_W  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   input  logic [15:0]       instr,
   output logic              instr_ready,
   output logic [3:0]        alu_operator,
   output logic [DATA_W-1:0] alu_op1,
   output logic [DATA_W-1:0] alu_op2,
   input  logic [DATA_W-1:0] alu_out,
   output logic              done,
   output logic              div_zero_err,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;

   state_t              state;
   logic [15:0]         ir;
   logic [DATA_W-1:0]   result;
   logic [DATA_W-1:0]   regs [REG_CNT];

   logic [3:0]          opcode;
   logic [ADDR_W-1:0]   rd;
   logic [ADDR_W-1:0]   rs1;
   logic [ADDR_W-1:0]   rs2;
   logic [DATA_W-1:0]   imm;
   logic [DATA_W-1:0]   rs1_val;
   logic [DATA_W-1:0]   rs2_val;
   logic                is_div;
   logic                unused_bits;

   assign opcode  = ir[15:12];
   assign rd      = ir[11:9];
   assign rs1     = ir[8:6];
   assign rs2     = ir[5:3];
   assign imm     = {{(DATA_W-9){1'b0}}, ir[8:0]};
   assign is_div  = (opcode == 4'h4) || (opcode == 4'h5);
   assign unused_bits = ^ir[2:0];

   assign rs1_val  = (rs1 == '0) ? '0 : regs[rs1];
   assign rs2_val  = (rs2 == '0) ? '0 : regs[rs2];
   assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

   // Gated with rst so ready stays low while reset is held, even though state is IDLE.
   assign instr_ready = rst && (state == IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         ir           <= '0;
         result       <= '0;
         alu_operator <= 4'hF;
         alu_op1      <= '0;
         alu_op2      <= '0;
         done         <= 1'b0;
         div_zero_err <= 1'b0;
         for (int unsigned i = 0; i < REG_CNT; i++) regs[i] <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (instr_valid) begin
                  ir    <= instr;
                  state <= FETCH;
               end
            end
            FETCH: begin
               if (!opcode[3]) begin
                  alu_operator <= opcode;
                  alu_op1      <= rs1_val;
                  alu_op2      <= rs2_val;
               end else begin
                  alu_operator <= 4'hF;
                  alu_op1      <= '0;
                  alu_op2      <= '0;
               end
               state <= EXEC;
            end
            EXEC: begin
               result <= alu_out;
               state  <= WB;
            end
            WB: begin
               if (!opcode[3]) begin
                  if (is_div && (alu_op2 == '0)) div_zero_err <= 1'b1;
                  else if (rd != '0)             regs[rd]     <= result;
               end else if ((opcode == 4'h8) && (rd != '0)) begin
                  regs[rd] <= imm;
               end
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Self-checking bench for alu_issue_seq: directed and random instructions
// checked against an architectural register-file model.
module tb_alu_issue_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic [15:0] instr;
   logic        instr_ready;
   logic [3:0]  alu_operator;
   logic [15:0] alu_op1;
   logic [15:0] alu_op2;
   logic [15:0] alu_out;
   logic        done;
   logic        div_zero_err;
   logic [2:0]  dbg_addr;
   logic [15:0] dbg_data;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int accepts = 0;
   int dones   = 0;

   logic [15:0] mregs [8];
   logic        merr;

   alu_issue_seq #(.DATA_W(16), .REG_CNT(8), .ADDR_W(3)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready), .alu_operator(alu_operator),
      .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_out(alu_out),
      .done(done), .div_zero_err(div_zero_err),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (instr_valid && instr_ready) accepts <= accepts + 1;
      if (done) dones <= dones + 1;
   end

   // Behavioural ALU; division by zero yields all-ones / the dividend.
   function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         4'h0: return a + b;
         4'h1: return a - b;
         4'h2: return 16'((32'(a) * 32'(b)) & 32'hFFFF);
         4'h3: return ~(a & b);
         4'h4: return (b == 0) ? 16'hFFFF : a / b;
         4'h5: return (b == 0) ? a : a % b;
         4'h6: return (a < b) ? 16'd1 : 16'd0;
         4'h7: return (a <= b) ? 16'd1 : 16'd0;
         default: return 16'h0000;
      endcase
   endfunction

   assign alu_out = alu_f(alu_operator, alu_op1, alu_op2);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
      merr = 1'b0;
   endtask

   task automatic model_apply(input logic [15:0] w);
      int op, rd;
      logic [15:0] a, b;
      op = int'(w[15:12]);
      rd = int'(w[11:9]);
      a  = mregs[w[8:6]];
      b  = mregs[w[5:3]];
      if (op < 8) begin
         if ((op == 4 || op == 5) && b == 0) merr = 1'b1;
         else if (rd != 0) mregs[rd] = alu_f(4'(op), a, b);
      end else if (op == 8 && rd != 0) begin
         mregs[rd] = {7'd0, w[8:0]};
      end
   endtask

   task automatic check_all_regs(input string tag);
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1;
         chk(tag, {16'd0, dbg_data}, {16'd0, mregs[i]});
      end
      chk({tag, "_err"}, {31'd0, div_zero_err}, {31'd0, merr});
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (!instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_ready_timeout"}, {31'd0, (n < 20)}, 32'd1);
   endtask

   // One instruction, fully checked cycle by cycle through retirement.
   task automatic issue(input logic [15:0] w);
      logic [3:0]  eop;
      logic [15:0] e1, e2;
      if (!w[15]) begin
         eop = w[15:12];
         e1  = mregs[w[8:6]];
         e2  = mregs[w[5:3]];
      end else begin
         eop = 4'hF;
         e1  = 16'h0;
         e2  = 16'h0;
      end
      wait_ready("issue");
      instr = w;
      instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
      @(negedge clk);
      chk("fetch_ready", {31'd0, instr_ready}, 32'd0);
      chk("fetch_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      chk("exec_ready", {31'd0, instr_ready}, 32'd0);
      chk("exec_operator", {28'd0, alu_operator}, {28'd0, eop});
      chk("exec_op1", {16'd0, alu_op1}, {16'd0, e1});
      chk("exec_op2", {16'd0, alu_op2}, {16'd0, e2});
      @(negedge clk);
      chk("wb_ready", {31'd0, instr_ready}, 32'd0);
      chk("wb_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      chk("retire_done", {31'd0, done}, 32'd1);
      chk("retire_ready", {31'd0, instr_ready}, 32'd1);
      model_apply(w);
      dbg_addr = w[11:9];
      #1;
      chk("retire_rd", {16'd0, dbg_data}, {16'd0, mregs[w[11:9]]});
      chk("retire_err", {31'd0, div_zero_err}, {31'd0, merr});
      @(negedge clk);
      chk("done_pulse_end", {31'd0, done}, 32'd0);
   endtask

   initial begin
      logic [15:0] q [$];
      logic [15:0] w;
      int t, tprev, acc0, dn0;

      rst = 1'b0;
      instr_valid = 1'b0;
      instr = 16'h0;
      dbg_addr = 3'd0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'd0, instr_ready}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_operator", {28'd0, alu_operator}, 32'hF);
      chk("rst_op1", {16'd0, alu_op1}, 32'd0);
      chk("rst_op2", {16'd0, alu_op2}, 32'd0);
      check_all_regs("rst_regs");
      rst = 1'b1;
      #1;
      chk("release_ready", {31'd0, instr_ready}, 32'd1);

      issue(16'h8205);
      issue(16'h8403);
      issue(16'h0650);
      chk("add_r3", {16'd0, mregs[3]}, 32'h8);
      issue(16'h4840);
      chk("div0_flag", {31'd0, div_zero_err}, 32'd1);
      issue(16'h0650);
      issue(16'h0650);
      chk("div0_sticky", {31'd0, div_zero_err}, 32'd1);
      issue(16'h81FF);
      dbg_addr = 3'd0;
      #1;
      chk("r0_zero", {16'd0, dbg_data}, 32'd0);
      issue(16'hA000);
      check_all_regs("directed_regs");

      for (int i = 0; i < 40; i++) begin
         w = 16'($urandom_range(0, 65535));
         if (i < 7) w = {4'h8, 3'(i + 1), 9'($urandom_range(0, 511))};
         issue(w);
      end
      check_all_regs("random_regs");

      // Back-to-back with instr_valid held high throughout.
      for (int i = 0; i < 30; i++) q.push_back(16'($urandom_range(0, 65535)));
      acc0 = accepts;
      dn0 = dones;
      tprev = 0;
      instr_valid = 1'b1;
      for (int k = 0; k < 30; k++) begin
         instr = q[k];
         wait_ready("b2b");
         @(posedge clk);
         #1;
         t = cyc;
         if (k > 0) chk("b2b_gap", 32'(t - tprev), 32'd4);
         tprev = t;
         model_apply(q[k]);
      end
      instr_valid = 1'b0;
      repeat (6) @(negedge clk);
      chk("b2b_accepts", 32'(accepts - acc0), 32'd30);
      chk("b2b_dones", 32'(dones - dn0), 32'd30);
      check_all_regs("b2b_regs");

      // Reset during EXEC of SUB r5,r1,r2.
      issue(16'h8207);
      issue(16'h8402);
      wait_ready("rst_mid");
      instr = 16'h1A50;
      instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
      dn0 = dones;
      @(negedge clk);
      @(negedge clk);
      chk("rst_mid_in_exec", {28'd0, alu_operator}, 32'h1);
      rst = 1'b0;
      #1;
      chk("rst_mid_ready", {31'd0, instr_ready}, 32'd0);
      @(negedge clk);
      chk("rst_mid_done", {31'd0, done}, 32'd0);
      rst = 1'b1;
      #1;
      chk("rst_mid_release_ready", {31'd0, instr_ready}, 32'd1);
      model_reset();
      check_all_regs("rst_mid_regs");
      repeat (4) @(negedge clk);
      chk("rst_mid_no_done", 32'(dones - dn0), 32'd0);
      issue(16'h8A2B);
      check_all_regs("final_regs");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
